// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: default widths,
// frame marker and the loader state encoding.
package imem_boot_loader_pkg;

   localparam int         PC_WIDTH          = 8;
   localparam int         TIMEOUT_DEFAULT   = 65535;
   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LEN_HI  = 3'd1,
      ST_LEN_LO  = 3'd2,
      ST_DATA_HI = 3'd3,
      ST_DATA_LO = 3'd4,
      ST_CHK     = 3'd5,
      ST_DONE    = 3'd6,
      ST_ERROR   = 3'd7
   } loader_state_t;

   // States in which a frame is in flight and the idle timeout runs.
   function automatic logic in_frame(input loader_state_t s);
      return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
             (s == ST_DATA_LO) || (s == ST_CHK);
   endfunction

endpackage

// File: rtl/imem_boot_loader_timeout_counter.sv
// Inter-byte idle counter for the boot loader. Counts cycles without an
// accepted byte while a frame is in flight and flags expiry at the limit.
module imem_boot_loader_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic byte_seen,
   output logic expired
);

   localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   // A byte on the limiting cycle suppresses expiry.
   assign expired = active && !byte_seen && (count == LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (!active || byte_seen || expired) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed byte stream, packs 16-bit words into
// instruction memory from address 0 and releases the core on a good checksum.
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter int         ADDR_W         = PC_WIDTH,
   parameter int         TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
   parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic              restart,
   output logic              imem_wr_en,
   output logic [ADDR_W-1:0] imem_wr_addr,
   output logic [15:0]       imem_wr_data,
   output logic              core_rst,
   output logic              load_done,
   output logic              load_error
);

   // state      | meaning
   // IDLE       | hunting for SYNC_BYTE, other bytes dropped
   // LEN_HI     | expecting length high byte
   // LEN_LO     | expecting length low byte, range check
   // DATA_HI    | expecting instruction high byte
   // DATA_LO    | expecting instruction low byte, schedules write
   // CHK        | expecting checksum byte
   // DONE       | image verified, core released
   // ERROR      | frame aborted, waiting for restart

   localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

   loader_state_t     state_q, state_d;
   logic              accept;
   logic              timed_out;
   logic [15:0]       len_q;
   logic [7:0]        hi_q;
   logic [7:0]        sum_q;
   logic [15:0]       words_q;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [15:0]       wr_data_q;

   assign rx_ready     = (state_q != ST_DONE) && (state_q != ST_ERROR);
   assign accept       = rx_valid && rx_ready;
   assign core_rst     = (state_q == ST_DONE);
   assign load_done    = (state_q == ST_DONE);
   assign load_error   = (state_q == ST_ERROR);
   assign imem_wr_en   = wr_en_q;
   assign imem_wr_addr = wr_addr_q;
   assign imem_wr_data = wr_data_q;

   imem_boot_loader_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .active   (in_frame(state_q)),
      .byte_seen(accept),
      .expired  (timed_out)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (timed_out) begin
         state_d = ST_ERROR;
      end else begin
         case (state_q)
            ST_IDLE:    if (accept && (rx_data == SYNC_BYTE)) state_d = ST_LEN_HI;
            ST_LEN_HI:  if (accept) state_d = ST_LEN_LO;
            ST_LEN_LO: begin
               if (accept) begin
                  if ({len_q[15:8], rx_data} == 16'h0000) begin
                     state_d = ST_CHK;
                  end else if ({1'b0, len_q[15:8], rx_data} > CAPACITY) begin
                     state_d = ST_ERROR;
                  end else begin
                     state_d = ST_DATA_HI;
                  end
               end
            end
            ST_DATA_HI: if (accept) state_d = ST_DATA_LO;
            ST_DATA_LO: begin
               if (accept) begin
                  state_d = (words_q + 16'd1 == len_q) ? ST_CHK : ST_DATA_HI;
               end
            end
            ST_CHK: begin
               if (accept) begin
                  state_d = ((sum_q + rx_data) == 8'h00) ? ST_DONE : ST_ERROR;
               end
            end
            ST_DONE, ST_ERROR: if (restart) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // The write is registered so the strobe lands one cycle after the low
   // byte and still completes if the frame aborts right afterwards.
   always_ff @(posedge clk) begin
      if (!rst) begin
         len_q     <= '0;
         hi_q      <= '0;
         sum_q     <= '0;
         words_q   <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= 1'b0;
         if (accept) begin
            case (state_q)
               ST_IDLE: begin
                  sum_q   <= '0;
                  words_q <= '0;
               end
               ST_LEN_HI: begin
                  len_q[15:8] <= rx_data;
                  sum_q       <= sum_q + rx_data;
               end
               ST_LEN_LO: begin
                  len_q[7:0] <= rx_data;
                  sum_q      <= sum_q + rx_data;
               end
               ST_DATA_HI: begin
                  hi_q  <= rx_data;
                  sum_q <= sum_q + rx_data;
               end
               ST_DATA_LO: begin
                  sum_q     <= sum_q + rx_data;
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= words_q[ADDR_W-1:0];
                  wr_data_q <= {hi_q, rx_data};
                  words_q   <= words_q + 16'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed vector table, hand-written
// corner sequences and random frames checked against a frame-level model.
module tb_imem_boot_loader;

   localparam int AW = 8;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          restart;
   logic          imem_wr_en;
   logic [AW-1:0] imem_wr_addr;
   logic [15:0]   imem_wr_data;
   logic          core_rst;
   logic          load_done;
   logic          load_error;

   imem_boot_loader #(
      .ADDR_W(AW),
      .TIMEOUT_CYCLES(TO),
      .SYNC_BYTE(8'hA5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .restart     (restart),
      .imem_wr_en  (imem_wr_en),
      .imem_wr_addr(imem_wr_addr),
      .imem_wr_data(imem_wr_data),
      .core_rst    (core_rst),
      .load_done   (load_done),
      .load_error  (load_error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   logic [AW-1:0] wa_q[$];
   logic [15:0]   wd_q[$];
   int            wc_q[$];
   int            acc_q[$];
   logic [7:0]    frame_q[$];
   logic [AW-1:0] mq_a[$];
   logic [15:0]   mq_d[$];
   logic          m_done;
   logic          m_err;

   always @(negedge clk) begin
      if (imem_wr_en) begin
         wa_q.push_back(imem_wr_addr);
         wd_q.push_back(imem_wr_data);
         wc_q.push_back(cyc);
      end
   end

   typedef struct packed {
      logic [63:0] b;
      logic [7:0]  n;
      logic        done;
      logic        err;
      logic [7:0]  nwr;
      logic [15:0] w0;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int budget = 40;
      bit got = 1'b0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!got && budget > 0) begin
         got = rx_ready;
         @(posedge clk);
         #1;
         budget--;
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_byte: byte %0h never accepted, rx_ready %0b expected 1", b, rx_ready);
      end else begin
         acc_q.push_back(cyc);
      end
   endtask

   task automatic send_frame(input int max_gap);
      int gap;
      for (int i = 0; i < frame_q.size(); i++) begin
         gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         if (gap > 0) begin
            rx_valid = 1'b0;
            tick(gap);
         end
         send_byte(frame_q[i]);
      end
      rx_valid = 1'b0;
   endtask

   task automatic clear_obs();
      wa_q.delete();
      wd_q.delete();
      wc_q.delete();
      acc_q.delete();
   endtask

   task automatic do_restart();
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      check("restart_rx_ready", 32'(rx_ready), 32'd1);
      check("restart_flags", {30'd0, load_done, load_error}, 32'd0);
      check("restart_core_rst", 32'(core_rst), 32'd0);
   endtask

   // Frame-level reference: find the marker, read the length, lay words out
   // from address 0 and judge the checksum over length and data bytes.
   task automatic model_frame();
      int i;
      logic [15:0] len;
      logic [7:0]  sum;
      logic [7:0]  t;
      mq_a.delete();
      mq_d.delete();
      m_done = 1'b0;
      m_err  = 1'b0;
      i = 0;
      while (i < frame_q.size() && frame_q[i] != 8'hA5) i++;
      if (i + 2 >= frame_q.size()) return;
      len = {frame_q[i+1], frame_q[i+2]};
      sum = frame_q[i+1] + frame_q[i+2];
      i += 3;
      if (int'(len) > (1 << AW)) begin
         m_err = 1'b1;
         return;
      end
      for (int k = 0; k < int'(len); k++) begin
         mq_a.push_back(AW'(k));
         mq_d.push_back({frame_q[i], frame_q[i+1]});
         sum = sum + frame_q[i] + frame_q[i+1];
         i += 2;
      end
      t = sum + frame_q[i];
      m_done = (t == 8'h00);
      m_err  = !m_done;
   endtask

   task automatic compare_model(input string tag);
      int n;
      check({tag, "_done"}, 32'(load_done), 32'(m_done));
      check({tag, "_error"}, 32'(load_error), 32'(m_err));
      check({tag, "_core_rst"}, 32'(core_rst), 32'(m_done));
      check({tag, "_nwrites"}, 32'(wa_q.size()), 32'(mq_a.size()));
      n = (wa_q.size() < mq_a.size()) ? wa_q.size() : mq_a.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "_addr"}, 32'(wa_q[i]), 32'(mq_a[i]));
         check({tag, "_data"}, 32'(wd_q[i]), 32'(mq_d[i]));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] sum;
      int len;
      rst      = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      restart  = 1'b0;
      tick(3);
      check("reset_rx_ready", 32'(rx_ready), 32'd1);
      check("reset_wr_en", 32'(imem_wr_en), 32'd0);
      check("reset_wr_addr", 32'(imem_wr_addr), 32'd0);
      check("reset_wr_data", 32'(imem_wr_data), 32'd0);
      check("reset_status", {29'd0, core_rst, load_done, load_error}, 32'd0);
      rst = 1'b1;
      tick(1);

      // Nominal load, every byte back to back, with strobe timing.
      clear_obs();
      frame_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
      for (int i = 0; i < 7; i++) send_byte(frame_q[i]);
      check("nom_core_rst_before_chk", 32'(core_rst), 32'd0);
      send_byte(frame_q[7]);
      rx_valid = 1'b0;
      check("nom_done_after_chk", 32'(load_done), 32'd1);
      check("nom_core_rst_after_chk", 32'(core_rst), 32'd1);
      check("nom_rx_ready_done", 32'(rx_ready), 32'd0);
      tick(2);
      check("nom_nwrites", 32'(wa_q.size()), 32'd2);
      if (wa_q.size() == 2 && acc_q.size() == 8) begin
         check("nom_w0_addr", 32'(wa_q[0]), 32'd0);
         check("nom_w0_data", 32'(wd_q[0]), 32'h1234);
         check("nom_w0_cycle", 32'(wc_q[0]), 32'(acc_q[4]));
         check("nom_w1_addr", 32'(wa_q[1]), 32'd1);
         check("nom_w1_data", 32'(wd_q[1]), 32'hABCD);
         check("nom_w1_cycle", 32'(wc_q[1]), 32'(acc_q[6]));
      end
      do_restart();

      // Bad checksum: writes still land, core stays in reset.
      clear_obs();
      frame_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
      send_frame(0);
      check("badchk_error", 32'(load_error), 32'd1);
      check("badchk_core_rst", 32'(core_rst), 32'd0);
      tick(2);
      check("badchk_nwrites", 32'(wa_q.size()), 32'd2);
      do_restart();

      // Directed vector table; bytes are listed first byte in the MSBs.
      vecs[0] = '{b: 64'h00FF_A500_0000_0000, n: 8'd6, done: 1'b1, err: 1'b0, nwr: 8'd0, w0: 16'h0000};
      vecs[1] = '{b: 64'hA501_0100_0000_0000, n: 8'd3, done: 1'b0, err: 1'b1, nwr: 8'd0, w0: 16'h0000};
      vecs[2] = '{b: 64'hA500_0112_34B9_0000, n: 8'd6, done: 1'b1, err: 1'b0, nwr: 8'd1, w0: 16'h1234};
      vecs[3] = '{b: 64'hA500_0112_34BA_0000, n: 8'd6, done: 1'b0, err: 1'b1, nwr: 8'd1, w0: 16'h1234};
      vecs[4] = '{b: 64'h5AA5_0000_0100_0000, n: 8'd5, done: 1'b0, err: 1'b1, nwr: 8'd0, w0: 16'h0000};
      for (int k = 0; k < 5; k++) begin
         clear_obs();
         frame_q.delete();
         for (int i = 0; i < int'(vecs[k].n); i++) frame_q.push_back(vecs[k].b[63-8*i -: 8]);
         send_frame(0);
         check($sformatf("vec%0d_done", k), 32'(load_done), 32'(vecs[k].done));
         check($sformatf("vec%0d_error", k), 32'(load_error), 32'(vecs[k].err));
         tick(2);
         check($sformatf("vec%0d_nwrites", k), 32'(wa_q.size()), 32'(vecs[k].nwr));
         if (vecs[k].nwr != 0 && wa_q.size() > 0) begin
            check($sformatf("vec%0d_w0_addr", k), 32'(wa_q[0]), 32'd0);
            check($sformatf("vec%0d_w0_data", k), 32'(wd_q[0]), 32'(vecs[k].w0));
         end
         do_restart();
      end

      // A byte arriving on the limiting idle cycle beats the timeout.
      clear_obs();
      frame_q = '{8'hA5, 8'h00, 8'h01};
      send_frame(0);
      tick(TO - 1);
      check("to_edge_no_error", 32'(load_error), 32'd0);
      send_byte(8'h12);
      check("to_edge_byte_wins", 32'(load_error), 32'd0);
      send_byte(8'h34);
      send_byte(8'hB9);
      rx_valid = 1'b0;
      check("to_edge_done", 32'(load_done), 32'd1);
      do_restart();

      // Full stall inside a word: error after exactly TO idle cycles.
      clear_obs();
      frame_q = '{8'hA5, 8'h00, 8'h01, 8'h12};
      send_frame(0);
      tick(TO - 1);
      check("to_before_limit", 32'(load_error), 32'd0);
      tick(1);
      check("to_at_limit", 32'(load_error), 32'd1);
      tick(2);
      check("to_nwrites", 32'(wa_q.size()), 32'd0);
      do_restart();

      // Reset mid-word: frame abandoned, next frame starts at address 0.
      frame_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
      send_frame(0);
      tick(2);
      clear_obs();
      rx_valid = 1'b1;
      rx_data  = 8'hAB;
      rst      = 1'b0;
      tick(1);
      rx_valid = 1'b0;
      check("rstmid_rx_ready", 32'(rx_ready), 32'd1);
      check("rstmid_status", {29'd0, core_rst, load_done, load_error}, 32'd0);
      check("rstmid_wr_en", 32'(imem_wr_en), 32'd0);
      rst = 1'b1;
      tick(3);
      check("rstmid_no_strobe", 32'(wa_q.size()), 32'd0);
      frame_q = '{8'hA5, 8'h00, 8'h01, 8'h56, 8'h78, 8'h31};
      send_frame(0);
      tick(2);
      model_frame();
      compare_model("rstmid_reload");
      do_restart();

      // Random frames with random gaps, checked against the frame model.
      for (int f = 0; f < 6; f++) begin
         clear_obs();
         frame_q.delete();
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
            logic [7:0] junk;
            junk = 8'($urandom_range(0, 255));
            frame_q.push_back((junk == 8'hA5) ? 8'h00 : junk);
         end
         len = (f == 0) ? 4 : (f == 2) ? (1 << AW) : int'($urandom_range(1, 8));
         frame_q.push_back(8'hA5);
         frame_q.push_back(8'(len >> 8));
         frame_q.push_back(8'(len));
         sum = 8'(len >> 8) + 8'(len);
         for (int j = 0; j < 2 * len; j++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            frame_q.push_back(d);
            sum = sum + d;
         end
         frame_q.push_back((f == 4) ? (8'h01 - sum) : (8'h00 - sum));
         model_frame();
         send_frame(4);
         tick(2);
         compare_model($sformatf("rand%0d", f));
         do_restart();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
